// File: rtl/mips_pkg.sv
// Shared definitions for the multiply/divide controller: operation codes,
// FSM states and default operation latencies.
package mips_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5,
        MADD  = 3'd6,
        MSUB  = 3'd7
    } md_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_t;

    localparam int unsigned MD_MULT_CYCLES = 5;
    localparam int unsigned MD_DIV_CYCLES  = 10;

endpackage

// File: rtl/muldiv_alu.sv
// Combinational 64-bit result generator for mult/multu/div/divu/madd/msub.
// res_hi/res_lo hold the value HI/LO would take; div_zero flags a zero divisor.
module muldiv_alu
    import mips_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] acc;
    logic [31:0] divisor;
    logic [31:0] abs_rs;
    logic [31:0] abs_rt;
    logic [31:0] uq;
    logic [31:0] ur;
    md_op_t      op_e;

    assign op_e = md_op_t'(op);

    always_comb begin
        prod_s  = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
        prod_u  = {32'd0, rs} * {32'd0, rt};
        acc     = {hi, lo};
        // A zero divisor is replaced by 1 so the dividers never see 0; the
        // result is discarded via div_zero anyway.
        divisor = (rt == 32'd0) ? 32'd1 : rt;
        // Sign-magnitude divide keeps 0x80000000 / -1 well defined.
        abs_rs  = rs[31] ? (32'd0 - rs) : rs;
        abs_rt  = divisor[31] ? (32'd0 - divisor) : divisor;
        uq      = abs_rs / abs_rt;
        ur      = abs_rs % abs_rt;
        res_hi  = hi;
        res_lo  = lo;
        div_zero = 1'b0;
        case (op_e)
            MULT:  {res_hi, res_lo} = prod_s;
            MULTU: {res_hi, res_lo} = prod_u;
            DIV: begin
                res_lo   = (rs[31] ^ divisor[31]) ? (32'd0 - uq) : uq;
                res_hi   = rs[31] ? (32'd0 - ur) : ur;
                div_zero = (rt == 32'd0);
            end
            DIVU: begin
                res_lo   = rs / divisor;
                res_hi   = rs % divisor;
                div_zero = (rt == 32'd0);
            end
            MADD:  {res_hi, res_lo} = acc + prod_s;
            MSUB:  {res_hi, res_lo} = acc - prod_s;
            default: begin
                res_hi = hi;
                res_lo = lo;
            end
        endcase
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// E-stage multiply/divide sequencer owning HI/LO and the HI/LO stall request.
// MADD/MSUB are legal only when MULDIV_MADD_EN is defined.
module muldiv_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use_d,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_t          state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        res_hi;
    logic [31:0]        res_lo;
    logic               commit_ok;
    logic [31:0]        alu_hi;
    logic [31:0]        alu_lo;
    logic               div_zero;
    logic               multi_op;
    logic               div_op;
    md_op_t             op_e;

    assign op_e = md_op_t'(md_op);

    muldiv_alu u_alu (
        .op       (md_op),
        .rs       (rs_val),
        .rt       (rt_val),
        .hi       (hi),
        .lo       (lo),
        .res_hi   (alu_hi),
        .res_lo   (alu_lo),
        .div_zero (div_zero)
    );

    always_comb begin
        multi_op = 1'b0;
        div_op   = 1'b0;
        case (op_e)
            MULT, MULTU: multi_op = 1'b1;
            DIV, DIVU: begin
                multi_op = 1'b1;
                div_op   = 1'b1;
            end
`ifdef MULDIV_MADD_EN
            MADD, MSUB: multi_op = 1'b1;
`else
            MADD, MSUB: multi_op = 1'b0;
`endif
            default: multi_op = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            res_hi    <= '0;
            res_lo    <= '0;
            commit_ok <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op_e == MTHI) begin
                            hi <= rs_val;
                        end else if (op_e == MTLO) begin
                            lo <= rs_val;
                        end else if (multi_op) begin
                            res_hi    <= alu_hi;
                            res_lo    <= alu_lo;
                            commit_ok <= !div_zero;
                            cnt       <= div_op ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                            state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                        if (commit_ok) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                    end
                end
            endcase
        end
    end

    assign busy      = (cnt != '0);
    assign stall_req = md_use_d & (start | busy);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: expected HI/LO/latency queued at issue,
// compared when the operation retires. Honours MULDIV_MADD_EN.
module tb_muldiv_ctrl;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_use_d;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cycles;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .md_op     (md_op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .md_use_d  (md_use_d),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset)
            assert (!(start && busy)) else $error("FAIL protocol: start while busy");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic exp_t model(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      p;
        longint      q;
        longint      r;
        logic [63:0] w;
        e.hi = hi_m;
        e.lo = lo_m;
        e.cycles = 0;
        p = longint'($signed(a)) * longint'($signed(b));
        case (op)
            MULT: begin
                w = p;
                {e.hi, e.lo} = w;
                e.cycles = 5;
            end
            MULTU: begin
                w = {32'd0, a} * {32'd0, b};
                {e.hi, e.lo} = w;
                e.cycles = 5;
            end
            DIV: begin
                e.cycles = 10;
                if (b != 0) begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    w = q;
                    e.lo = w[31:0];
                    w = r;
                    e.hi = w[31:0];
                end
            end
            DIVU: begin
                e.cycles = 10;
                if (b != 0) begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
            MTHI: e.hi = a;
            MTLO: e.lo = a;
`ifdef MULDIV_MADD_EN
            MADD: begin
                w = {hi_m, lo_m} + p;
                {e.hi, e.lo} = w;
                e.cycles = 5;
            end
            MSUB: begin
                w = {hi_m, lo_m} - p;
                {e.hi, e.lo} = w;
                e.cycles = 5;
            end
`endif
            default: e.cycles = 0;
        endcase
        return e;
    endfunction

    task automatic do_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b, input logic use_d);
        exp_t        e;
        int unsigned n;
        sb.push_back(model(op, a, b));
        @(negedge clk);
        start = 1'b1; md_op = op; rs_val = a; rt_val = b; md_use_d = use_d;
        #1;
        check($sformatf("stall_start_%s", op.name()), stall_req, use_d);
        @(negedge clk);
        start = 1'b0;
        #1;
        n = 0;
        while (busy && n < 50) begin
            check("stall_busy", stall_req, use_d);
            n++;
            @(negedge clk);
        end
        e = sb.pop_front();
        check($sformatf("cycles_%s", op.name()), n, e.cycles);
        check($sformatf("hi_%s", op.name()), hi, e.hi);
        check($sformatf("lo_%s", op.name()), lo, e.lo);
        check("stall_after", stall_req, 1'b0);
        hi_m = e.hi;
        lo_m = e.lo;
        md_use_d = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; md_op = '0; rs_val = '0; rt_val = '0; md_use_d = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_stall", stall_req, 1'b0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        reset = 1'b0;

        do_op(MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        do_op(DIVU, 32'd100, 32'd7, 1'b0);
        do_op(DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(MTHI, 32'hA5A5_A5A5, 32'd0, 1'b0);
        do_op(MTLO, 32'hA5A5_A5A5, 32'd0, 1'b0);
        do_op(DIV, 32'h1234_5678, 32'd0, 1'b0);
        do_op(DIVU, 32'hFFFF_FFFF, 32'd0, 1'b0);
        do_op(MULT, 32'd7, 32'hFFFF_FFFD, 1'b1);
        do_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        do_op(MTHI, 32'hDEAD_BEEF, 32'd0, 1'b1);

        do_op(MTHI, 32'd0, 32'd0, 1'b0);
        do_op(MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
        do_op(MADD, 32'd1, 32'd1, 1'b0);
        do_op(MSUB, 32'd3, 32'hFFFF_FFFF, 1'b0);
        do_op(MADD, 32'h8000_0000, 32'h8000_0000, 1'b0);

        for (int i = 0; i < 6; i++) begin
            do_op(md_op_t'($urandom_range(3, 0)), $urandom, $urandom_range(255, 0), 1'($urandom_range(1, 0)));
        end

        // Reset during the third busy cycle of a DIVU must abort with no commit.
        do_op(MTHI, 32'h1111_2222, 32'd0, 1'b0);
        @(negedge clk);
        start = 1'b1; md_op = DIVU; rs_val = 32'd100; rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_busy_pre", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_nocommit_hi", hi, 32'd0);
        check("abort_nocommit_lo", lo, 32'd0);
        check("abort_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
